fib_stack_ctrl: RTL and testbench
=================================

Name: fib_stack_ctrl

Overview:
- Controller at the initiator end of the 128-bit push/pop/tos stack interface.
- Computes fib(n) by tree recursion emulated on the stack: push n, then repeatedly pop x; if x<2 add x to an accumulator, else push x-1 and x-2; stop when the stack is empty.
- Sits between the top-level start/result handshake and the stack instance. It is the only agent driving that stack.

Parameters:
- N_W, 6, width of the input operand n (n is zero-extended to DATA_W when pushed).
- DATA_W, 128, stack data and result width. Must match the stack word width.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high; also wired to the stack's reset
- start  in  1  request; sampled only in IDLE
- n  in  N_W  operand; sampled on the start edge
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; result is valid in the same cycle
- result  out  DATA_W  fib(n); held until the next done
- stk_push  out  1  stack push command
- stk_pop  out  1  stack pop command
- stk_tos  out  1  tied 0 (reserved)
- stk_d_in  out  DATA_W  value to push
- stk_d_out  in  DATA_W  stack registered read data; valid the cycle after a pop
- stk_empty  in  1  stack empty flag; reflects the pointer after the previous edge

Behaviour:
- Reset:
  - state=IDLE, acc=0, x_reg=0, result=0, done=0, busy=0.
  - stk_push, stk_pop and stk_tos are 0; stk_d_in=0.
  - Reset mid-operation aborts the computation. The shared rst empties the stack at the same time; no partial result is produced.
- Stack commands are Moore outputs decoded from state. At most one of push/pop is high in any cycle.
- FSM states:
  - IDLE: if start, then acc<=0, n_reg<=n, go to PUSH_N. Otherwise stay.
  - PUSH_N: stk_push=1, stk_d_in=zero-extended n_reg; go to CHECK.
  - CHECK: if stk_empty, then result<=acc and go to DONE; else go to POP.
  - POP: stk_pop=1; go to EVAL.
  - EVAL: x=stk_d_out.
    - If x<2: acc<=acc+x (DATA_W-bit wrap, no flag), go to CHECK.
    - Else: x_reg<=x, go to PUSH_A.
  - PUSH_A: stk_push=1, stk_d_in=x_reg-1; go to PUSH_B.
  - PUSH_B: stk_push=1, stk_d_in=x_reg-2; go to CHECK.
  - DONE: done=1 for one cycle; go to IDLE.
- Handshake:
  - start while busy is ignored; it is not queued.
  - start in IDLE on the same edge that returns from DONE is accepted normally.
- Latency:
  - L=fib(n+1) leaves (3 cycles each), I=fib(n+1)-1 internal nodes (5 cycles each).
  - done is asserted 2+3L+5I rising edges after the edge that samples start.
- Stack depth never exceeds n+1 entries. The controller never pops when stk_empty=1.
- Precondition: the stack is empty when start is accepted. Guaranteed because every run drains the stack fully, and reset clears it.
- n=0 and n=1 are each a single leaf, giving result 0 and 1 respectively.
- Runtime is exponential in n. Bench n values are limited to ≤20.

Decomposition:
- Shared package fib_pkg holds:
  - DATA_W=128 and the stack address width 16
  - state encoding constants: IDLE, PUSH_N, CHECK, POP, EVAL, PUSH_A, PUSH_B, DONE
- No sub-module is warranted. The block is one FSM plus the acc, x_reg, n_reg and result registers.
- The bench instantiates fib_stack_ctrl together with the existing stack block.

Test Plan:
- n=0, one start pulse -> done at edge 5 after the start edge; result=0; busy high from edge 1 to edge 5.
- n=1 -> done at edge 5; result=1. Then n=2 -> done at edge 13; result=1.
- n=10 -> result=55, done at edge 709. Assert push&pop is never high together, and pop is never issued while stk_empty=1.
- Back-to-back: n=5 (result 5, 61 edges), then start held high continuously -> second run starts the edge after DONE and gives result 5 again. start pulses while busy have no effect.
- rst asserted mid-run (n=8, after 30 cycles) -> busy=0, done=0, result=0 immediately. A new start with n=3 -> result=2 at edge 2+3·3+5·2=21.

Source files
------------

// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// fib_pkg : shared widths and FSM encoding for the Fibonacci stack controller
// Revision: 1.0
// ============================================================================
package fib_pkg;

   localparam int DATA_W = 128;
   localparam int STK_AW = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PUSH_N = 3'd1,
      CHECK  = 3'd2,
      POP    = 3'd3,
      EVAL   = 3'd4,
      PUSH_A = 3'd5,
      PUSH_B = 3'd6,
      DONE   = 3'd7
   } state_t;

endpackage : fib_pkg
`default_nettype wire

// File: rtl/fib_stack_ctrl.sv
`default_nettype none
// ============================================================================
// fib_stack_ctrl : computes fib(n) by tree recursion emulated on an external stack
// Revision: 1.0
// ============================================================================
module fib_stack_ctrl
   import fib_pkg::*;
#(
   parameter int N_W    = 6,
   parameter int DATA_W = fib_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N_W-1:0]    n,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              stk_push,
   output logic              stk_pop,
   output logic              stk_tos,
   output logic [DATA_W-1:0] stk_d_in,
   input  logic [DATA_W-1:0] stk_d_out,
   input  logic              stk_empty
);

   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
   localparam logic [DATA_W-1:0] TWO = DATA_W'(2);

   state_t             state_q, state_d;
   logic [DATA_W-1:0]  acc_q, acc_d;
   logic [DATA_W-1:0]  x_q, x_d;
   logic [N_W-1:0]     n_q, n_d;
   logic [DATA_W-1:0]  result_q, result_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         x_q      <= '0;
         n_q      <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         x_q      <= x_d;
         n_q      <= n_d;
         result_q <= result_d;
      end
   end

   // Stack commands are pure state decodes, so push and pop can never overlap.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      x_d      = x_q;
      n_d      = n_q;
      result_d = result_q;
      stk_push = 1'b0;
      stk_pop  = 1'b0;
      stk_d_in = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = '0;
               n_d     = n;
               state_d = PUSH_N;
            end
         end
         PUSH_N: begin
            stk_push = 1'b1;
            stk_d_in = {{(DATA_W-N_W){1'b0}}, n_q};
            state_d  = CHECK;
         end
         CHECK: begin
            if (stk_empty) begin
               result_d = acc_q;
               state_d  = DONE;
            end else begin
               state_d  = POP;
            end
         end
         POP: begin
            stk_pop = 1'b1;
            state_d = EVAL;
         end
         EVAL: begin
            if (stk_d_out < TWO) begin
               acc_d   = acc_q + stk_d_out;
               state_d = CHECK;
            end else begin
               x_d     = stk_d_out;
               state_d = PUSH_A;
            end
         end
         PUSH_A: begin
            stk_push = 1'b1;
            stk_d_in = x_q - ONE;
            state_d  = PUSH_B;
         end
         PUSH_B: begin
            stk_push = 1'b1;
            stk_d_in = x_q - TWO;
            state_d  = CHECK;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign result  = result_q;
   assign stk_tos = 1'b0;

endmodule : fib_stack_ctrl
`default_nettype wire

// File: tb/tb_fib_stack_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fib_stack_ctrl : directed self-checking bench with a behavioural stack
// Revision: 1.0
// ============================================================================
module tb_fib_stack_ctrl;
   import fib_pkg::*;

   localparam int N_W   = 6;
   localparam int DW    = 128;
   localparam int DEPTH = 64;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [N_W-1:0] n_in = '0;
   logic           busy, done, stk_push, stk_pop, stk_tos, stk_empty;
   logic [DW-1:0]  result, stk_d_in, stk_d_out;

   int compared   = 0;
   int mismatched = 0;
   int viol       = 0;
   int max_depth  = 0;

   always #5 clk = ~clk;

   fib_stack_ctrl #(.N_W(N_W), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .n(n_in),
      .busy(busy), .done(done), .result(result),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_tos(stk_tos),
      .stk_d_in(stk_d_in), .stk_d_out(stk_d_out), .stk_empty(stk_empty)
   );

   // Behavioural stand-in for the stack: registered pop data, empty from pointer.
   logic [DW-1:0] mem [DEPTH];
   logic [15:0]   sp;
   assign stk_empty = (sp == 16'd0);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sp        <= '0;
         stk_d_out <= '0;
      end else if (stk_push) begin
         mem[sp[5:0]] <= stk_d_in;
         sp           <= sp + 16'd1;
      end else if (stk_pop) begin
         stk_d_out <= mem[sp[5:0] - 6'd1];
         sp        <= sp - 16'd1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (stk_push && stk_pop) viol++;
         if (stk_pop && stk_empty) viol++;
         if (int'(sp) > max_depth) max_depth = int'(sp);
      end
   end

   // Pulses start for one sampling edge and counts edges until done.
   // inject_at>0 raises a spurious start (n=1) at that edge count.
   task automatic run_one(input logic [N_W-1:0] nv, input logic [DW-1:0] exp_res,
                          input int exp_lat, input int inject_at, input string name);
      int k;
      bit seen;
      @(negedge clk);
      start = 1'b1;
      n_in  = nv;
      @(posedge clk);
      #1;
      start = 1'b0;
      compared++;
      if (busy !== 1'b1) begin
         mismatched++;
         $display("FAIL %s busy_after_start: got %b want 1", name, busy);
      end
      seen = 1'b0;
      k = 0;
      while (!seen && k < 2000) begin
         if (inject_at > 0 && k == inject_at) begin
            start = 1'b1;
            n_in  = 6'd1;
         end else if (inject_at > 0 && k == inject_at + 3) begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         k++;
         if (done === 1'b1) seen = 1'b1;
      end
      start = 1'b0;
      compared++;
      if (k !== exp_lat) begin
         mismatched++;
         $display("FAIL %s latency: got %0d edges want %0d", name, k, exp_lat);
      end
      compared++;
      if (result !== exp_res) begin
         mismatched++;
         $display("FAIL %s result: got %0d want %0d", name, result, exp_res);
      end
      @(posedge clk);
      #1;
      compared++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         mismatched++;
         $display("FAIL %s after_done: got done=%b busy=%b want 0 0", name, done, busy);
      end
   endtask

   task automatic test_reset();
      #1;
      compared++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || stk_push !== 1'b0 ||
          stk_pop !== 1'b0 || stk_tos !== 1'b0 || stk_d_in !== '0) begin
         mismatched++;
         $display("FAIL reset_outputs: got busy=%b done=%b result=%0d push=%b pop=%b tos=%b din=%0d want all 0",
                  busy, done, result, stk_push, stk_pop, stk_tos, stk_d_in);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_small();
      run_one(6'd0, 128'd0, 5, 0, "n0");
      run_one(6'd1, 128'd1, 5, 0, "n1");
      run_one(6'd2, 128'd1, 13, 0, "n2");
   endtask

   task automatic test_n10();
      viol = 0;
      max_depth = 0;
      run_one(6'd10, 128'd55, 709, 0, "n10");
      compared++;
      if (viol !== 0) begin
         mismatched++;
         $display("FAIL n10_stack_protocol: got %0d violations want 0", viol);
      end
      compared++;
      if (max_depth > 11) begin
         mismatched++;
         $display("FAIL n10_depth: got %0d want <=11", max_depth);
      end
   endtask

   task automatic test_back_to_back();
      int k;
      bit seen;
      // Spurious start while busy must be ignored.
      run_one(6'd5, 128'd5, 61, 20, "n5_ignore");
      // Start held high across two runs.
      @(negedge clk);
      start = 1'b1;
      n_in  = 6'd5;
      @(posedge clk);
      #1;
      seen = 1'b0;
      k = 0;
      while (!seen && k < 2000) begin
         @(posedge clk);
         #1;
         k++;
         if (done === 1'b1) seen = 1'b1;
      end
      compared++;
      if (k !== 61 || result !== 128'd5) begin
         mismatched++;
         $display("FAIL b2b_first: got lat=%0d res=%0d want 61 5", k, result);
      end
      @(posedge clk);
      #1;
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("FAIL b2b_idle_gap: got busy=%b want 0", busy);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      compared++;
      if (busy !== 1'b1) begin
         mismatched++;
         $display("FAIL b2b_restart: got busy=%b want 1", busy);
      end
      seen = 1'b0;
      k = 0;
      while (!seen && k < 2000) begin
         @(posedge clk);
         #1;
         k++;
         if (done === 1'b1) seen = 1'b1;
      end
      compared++;
      if (k !== 61 || result !== 128'd5) begin
         mismatched++;
         $display("FAIL b2b_second: got lat=%0d res=%0d want 61 5", k, result);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      start = 1'b1;
      n_in  = 6'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      compared++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== '0) begin
         mismatched++;
         $display("FAIL mid_reset: got busy=%b done=%b result=%0d want 0 0 0", busy, done, result);
      end
      @(negedge clk);
      rst = 1'b0;
      run_one(6'd3, 128'd2, 21, 0, "n3_after_rst");
   endtask

   initial begin
      test_reset();
      test_small();
      test_n10();
      test_back_to_back();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_fib_stack_ctrl
`default_nettype wire
